// File: rtl/Instruction_pkg.sv
// rtl/Instruction_pkg.sv - instruction-level enumerations shared across the core
package Instruction_pkg;

   // Codes 4..7 are unassigned and must produce a zero result.
   typedef enum logic [2:0] {
      MUL_    = 3'd0,
      MULH_   = 3'd1,
      MULHSU_ = 3'd2,
      MULHU_  = 3'd3
   } mul_ops_e;

endpackage

// File: rtl/Modules_pkg.sv
// rtl/Modules_pkg.sv - shared module-level types and limits
package Modules_pkg;

   import Instruction_pkg::*;

   localparam int MUL_MAX_STAGES = 6;
   localparam int MUL_MAX_TAG_W  = 16;

   // Tag field is sized for the widest user; narrower tags are zero-extended.
   typedef struct packed {
      logic                     valid;
      mul_ops_e                 op;
      logic [MUL_MAX_TAG_W-1:0] tag;
   } mul_stage_s;

endpackage

// File: rtl/signed_mult_core.sv
// rtl/signed_mult_core.sv - W x W signed multiplier followed by LAT enable-gated registers
module signed_mult_core #(
   parameter int W   = 33,
   parameter int LAT = 2
) (
   input  logic           clk_i,
   input  logic           ce_i,
   input  logic [W-1:0]   a_i,
   input  logic [W-1:0]   b_i,
   output logic [2*W-1:0] p_o
);

   logic [2*W-1:0] a_x;
   logic [2*W-1:0] b_x;
   logic [2*W-1:0] prod;
   logic [2*W-1:0] pipe_d [LAT];
   logic [2*W-1:0] pipe_q [LAT];

   // Sign-extending to full width lets a plain modular multiply yield the signed product.
   assign a_x  = {{W{a_i[W-1]}}, a_i};
   assign b_x  = {{W{b_i[W-1]}}, b_i};
   assign prod = a_x * b_x;

   always_comb begin
      for (int i = 0; i < LAT; i++) begin
         pipe_d[i] = pipe_q[i];
      end
      if (ce_i) begin
         pipe_d[0] = prod;
         for (int i = 1; i < LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < LAT; i++) begin
         pipe_q[i] <= pipe_d[i];
      end
   end

   assign p_o = pipe_q[LAT-1];

endmodule

// File: rtl/mul_unit_pipe.sv
// rtl/mul_unit_pipe.sv - pipelined RV32M/RV64M multiply unit with valid/tag tracking, stall and flush
module mul_unit_pipe
   import Instruction_pkg::*;
   import Modules_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int STAGES = 3,
   parameter int TAG_W  = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clk_en_i,
   input  logic             flush_i,
   input  logic             valid_i,
   input  mul_ops_e         ops_i,
   input  logic [XLEN-1:0]  multiplicand_i,
   input  logic [XLEN-1:0]  multiplier_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             valid_o,
   output logic [XLEN-1:0]  result_o,
   output logic [TAG_W-1:0] tag_o,
   output logic             busy_o
);

   localparam int PW = 2 * (XLEN + 1);

   mul_stage_s    meta_d [STAGES];
   mul_stage_s    meta_q [STAGES];
   logic [XLEN:0] a_ext_d, a_ext_q;
   logic [XLEN:0] b_ext_d, b_ext_q;
   logic [PW-1:0] prod;
   logic          sign_a, sign_b;
   mul_stage_s    out_s;
   logic          prod_unused;

   always_comb begin
      sign_a  = (ops_i == MUL_) || (ops_i == MULH_) || (ops_i == MULHSU_);
      sign_b  = (ops_i == MUL_) || (ops_i == MULH_);
      a_ext_d = a_ext_q;
      b_ext_d = b_ext_q;
      for (int i = 0; i < STAGES; i++) begin
         meta_d[i] = meta_q[i];
      end
      if (clk_en_i) begin
         a_ext_d         = {sign_a & multiplicand_i[XLEN-1], multiplicand_i};
         b_ext_d         = {sign_b & multiplier_i[XLEN-1], multiplier_i};
         meta_d[0].valid = valid_i;
         meta_d[0].op    = ops_i;
         meta_d[0].tag   = MUL_MAX_TAG_W'(tag_i);
         for (int i = 1; i < STAGES; i++) begin
            meta_d[i] = meta_q[i-1];
         end
      end
      // Flush only kills the valid bits; stale data behind them is harmless.
      if (flush_i) begin
         for (int i = 0; i < STAGES; i++) begin
            meta_d[i].valid = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < STAGES; i++) begin
            meta_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            meta_q[i] <= meta_d[i];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      a_ext_q <= a_ext_d;
      b_ext_q <= b_ext_d;
   end

   signed_mult_core #(
      .W   (XLEN + 1),
      .LAT (STAGES - 1)
   ) u_core (
      .clk_i (clk_i),
      .ce_i  (clk_en_i),
      .a_i   (a_ext_q),
      .b_i   (b_ext_q),
      .p_o   (prod)
   );

   assign out_s = meta_q[STAGES-1];

   always_comb begin
      valid_o  = out_s.valid;
      result_o = '0;
      tag_o    = '0;
      if (out_s.valid) begin
         tag_o = out_s.tag[TAG_W-1:0];
         case (out_s.op)
            MUL_:                   result_o = prod[XLEN-1:0];
            MULH_, MULHSU_, MULHU_: result_o = prod[2*XLEN-1:XLEN];
            default:                result_o = '0;
         endcase
      end
   end

   always_comb begin
      busy_o = 1'b0;
      for (int i = 0; i < STAGES; i++) begin
         busy_o = busy_o | meta_q[i].valid;
      end
   end

   // The two product MSBs only exist to hold the extended sign and are never selected.
   assign prod_unused = ^{prod[PW-1:2*XLEN], out_s.tag};

endmodule

// File: tb/tb_mul_unit_pipe.sv
// tb/tb_mul_unit_pipe.sv - self-checking bench for mul_unit_pipe against a behavioural model
module tb_mul_unit_pipe;
   import Instruction_pkg::*;

   localparam int STG [3] = '{3, 2, 5};
   localparam int XL  [3] = '{32, 32, 64};

   logic        clk = 1'b0;
   logic        rst, en, fl, vin;
   mul_ops_e    ops;
   logic [63:0] a, b;
   logic [4:0]  tag;

   logic        v0, v1, v2, bz0, bz1, bz2;
   logic [31:0] r0, r1;
   logic [63:0] r2;
   logic [4:0]  t0, t1, t2;

   always #5 clk = ~clk;

   mul_unit_pipe #(.XLEN(32), .STAGES(3), .TAG_W(5)) u_p32s3 (
      .clk_i(clk), .rst_i(rst), .clk_en_i(en), .flush_i(fl), .valid_i(vin), .ops_i(ops),
      .multiplicand_i(a[31:0]), .multiplier_i(b[31:0]), .tag_i(tag),
      .valid_o(v0), .result_o(r0), .tag_o(t0), .busy_o(bz0));

   mul_unit_pipe #(.XLEN(32), .STAGES(2), .TAG_W(5)) u_p32s2 (
      .clk_i(clk), .rst_i(rst), .clk_en_i(en), .flush_i(fl), .valid_i(vin), .ops_i(ops),
      .multiplicand_i(a[31:0]), .multiplier_i(b[31:0]), .tag_i(tag),
      .valid_o(v1), .result_o(r1), .tag_o(t1), .busy_o(bz1));

   mul_unit_pipe #(.XLEN(64), .STAGES(5), .TAG_W(5)) u_p64s5 (
      .clk_i(clk), .rst_i(rst), .clk_en_i(en), .flush_i(fl), .valid_i(vin), .ops_i(ops),
      .multiplicand_i(a), .multiplier_i(b), .tag_i(tag),
      .valid_o(v2), .result_o(r2), .tag_o(t2), .busy_o(bz2));

   typedef struct {
      int          inst;
      logic [63:0] res;
      logic [4:0]  tag;
      int          rem;
   } ent_t;

   typedef struct {
      int          c;
      logic [31:0] r;
      logic [4:0]  t;
   } cap_t;

   ent_t mq[$];
   cap_t cap[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic logic [63:0] ref_mul(mul_ops_e op, logic [63:0] x, logic [63:0] y, int xl);
      logic [127:0] m, ex, ey, p, sel;
      bit sx, sy;
      m  = (128'd1 << xl) - 128'd1;
      sx = (op == MUL_) || (op == MULH_) || (op == MULHSU_);
      sy = (op == MUL_) || (op == MULH_);
      ex = {64'd0, x} & m;
      ey = {64'd0, y} & m;
      if (sx && x[xl-1]) ex = ex | ~m;
      if (sy && y[xl-1]) ey = ey | ~m;
      p = ex * ey;
      case (op)
         MUL_:                   sel = p & m;
         MULH_, MULHSU_, MULHU_: sel = (p >> xl) & m;
         default:                sel = 128'd0;
      endcase
      return sel[63:0];
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Model: each in-flight op counts down advancing edges until it is shown at zero.
   always @(posedge clk) begin
      cyc++;
      if (rst || fl) begin
         mq.delete();
      end else if (en) begin
         for (int k = mq.size() - 1; k >= 0; k--) begin
            ent_t e;
            e = mq[k];
            if (e.rem == 0) mq.delete(k);
            else begin
               e.rem--;
               mq[k] = e;
            end
         end
         if (vin) begin
            for (int i = 0; i < 3; i++) begin
               ent_t e;
               e.inst = i;
               e.res  = ref_mul(ops, a, b, XL[i]);
               e.tag  = tag;
               e.rem  = STG[i] - 1;
               mq.push_back(e);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cyc >= 1) begin
         for (int i = 0; i < 3; i++) begin
            logic        ev, eb, av, ab;
            logic [63:0] er, ar;
            logic [4:0]  et, at;
            ev = 1'b0; eb = 1'b0; er = '0; et = '0;
            foreach (mq[k]) begin
               if (mq[k].inst == i) begin
                  eb = 1'b1;
                  if (mq[k].rem == 0) begin
                     ev = 1'b1;
                     er = mq[k].res;
                     et = mq[k].tag;
                  end
               end
            end
            case (i)
               0:       begin av = v0; ab = bz0; ar = {32'd0, r0}; at = t0; end
               1:       begin av = v1; ab = bz1; ar = {32'd0, r1}; at = t1; end
               default: begin av = v2; ab = bz2; ar = r2;          at = t2; end
            endcase
            chk($sformatf("valid_o[%0d]", i), {63'd0, av}, {63'd0, ev});
            chk($sformatf("busy_o[%0d]", i), {63'd0, ab}, {63'd0, eb});
            chk($sformatf("result_o[%0d]", i), ar, er);
            chk($sformatf("tag_o[%0d]", i), {59'd0, at}, {59'd0, et});
         end
         if (v0 === 1'b1) begin
            cap_t c;
            c.c = cyc; c.r = r0; c.t = t0;
            cap.push_back(c);
         end
      end
   end

   task automatic drive(bit v, mul_ops_e op, logic [63:0] aa, logic [63:0] bb, logic [4:0] tg,
                        bit e, bit f, bit r);
      @(negedge clk);
      vin = v; ops = op; a = aa; b = bb; tag = tg; en = e; fl = f; rst = r;
   endtask

   task automatic issue(mul_ops_e op, logic [63:0] aa, logic [63:0] bb, logic [4:0] tg);
      drive(1'b1, op, aa, bb, tg, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic idles(int n);
      for (int i = 0; i < n; i++) drive(1'b0, MUL_, 64'd0, 64'd0, 5'd0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic chk_cap(string nm, int k, int c, logic [31:0] r, logic [4:0] t);
      if (k >= cap.size()) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: only %0d results captured, required entry %0d", nm, cap.size(), k);
      end else begin
         chk({nm, "_cycle"}, 64'(cap[k].c), 64'(c));
         chk({nm, "_result"}, {32'd0, cap[k].r}, {32'd0, r});
         chk({nm, "_tag"}, {59'd0, cap[k].t}, {59'd0, t});
      end
   endtask

   function automatic logic [63:0] rnd_operand();
      case ($urandom % 4)
         0:       return 64'hFFFF_FFFF_FFFF_FFFF;
         1:       return 64'h8000_0000_8000_0000;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      int acc;
      rst = 1'b1; en = 1'b0; fl = 1'b0; vin = 1'b0; ops = MUL_; a = '0; b = '0; tag = '0;

      chk("model_mulhu32", ref_mul(MULHU_, 64'h1234_5678, 64'h9ABC_DEF0, 32), 64'h0B00_EA4E);
      chk("model_mulhsu64", ref_mul(MULHSU_, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64),
          64'hFFFF_FFFF_FFFF_FFFF);
      chk("model_mul64", ref_mul(MUL_, 64'h1_0000_0001, 64'h1_0000_0001, 64), 64'h2_0000_0001);
      chk("model_undef", ref_mul(mul_ops_e'(3'd5), 64'd3, 64'd3, 32), 64'd0);

      repeat (2) @(negedge clk);
      chk("reset_valid", {63'd0, v0}, 64'd0);
      chk("reset_busy", {63'd0, bz0}, 64'd0);
      chk("reset_result", {32'd0, r0}, 64'd0);
      chk("reset_tag", {59'd0, t0}, 64'd0);
      idles(2);

      // All-ones operands through each op back to back.
      cap.delete();
      issue(MUL_, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd1);
      acc = cyc + 1;
      issue(MULH_, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd2);
      issue(MULHSU_, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd3);
      issue(MULHU_, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd4);
      idles(6);
      chk("t1_count", 64'(cap.size()), 64'd4);
      chk_cap("t1_mul", 0, acc + 2, 32'h0000_0001, 5'd1);
      chk_cap("t1_mulh", 1, acc + 3, 32'h0000_0000, 5'd2);
      chk_cap("t1_mulhsu", 2, acc + 4, 32'hFFFF_FFFF, 5'd3);
      chk_cap("t1_mulhu", 3, acc + 5, 32'hFFFF_FFFE, 5'd4);

      // Most-negative operands.
      cap.delete();
      issue(MULH_, 64'h8000_0000, 64'h8000_0000, 5'd5);
      acc = cyc + 1;
      issue(MUL_, 64'h8000_0000, 64'h8000_0000, 5'd6);
      issue(MULHU_, 64'h8000_0000, 64'h8000_0000, 5'd7);
      issue(MULHSU_, 64'h8000_0000, 64'h8000_0000, 5'd8);
      idles(6);
      chk_cap("t2_mulh", 0, acc + 2, 32'h4000_0000, 5'd5);
      chk_cap("t2_mul", 1, acc + 3, 32'h0000_0000, 5'd6);
      chk_cap("t2_mulhu", 2, acc + 4, 32'h4000_0000, 5'd7);
      chk_cap("t2_mulhsu", 3, acc + 5, 32'hC000_0000, 5'd8);

      // Three stall cycles mid-flight delay the result by exactly three cycles.
      cap.delete();
      issue(MULHU_, 64'h1234_5678, 64'h9ABC_DEF0, 5'd7);
      acc = cyc + 1;
      idles(1);
      repeat (3) drive(1'b0, MUL_, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      idles(6);
      chk("t3_count", 64'(cap.size()), 64'd1);
      chk_cap("t3_stall", 0, acc + 5, 32'h0B00_EA4E, 5'd7);

      // Flush with a concurrent op and stalled enable drops everything.
      cap.delete();
      issue(MUL_, 64'd3, 64'd5, 5'd9);
      issue(MULH_, 64'd7, 64'd9, 5'd10);
      drive(1'b1, MULHU_, 64'd11, 64'd13, 5'd11, 1'b0, 1'b1, 1'b0);
      idles(1);
      chk("t4_valid", {63'd0, v0}, 64'd0);
      chk("t4_busy", {61'd0, bz0, bz1, bz2}, 64'd0);
      idles(6);
      chk("t4_none", 64'(cap.size()), 64'd0);
      issue(MULHU_, 64'h1234_5678, 64'h9ABC_DEF0, 5'd12);
      acc = cyc + 1;
      idles(5);
      chk_cap("t4_after", 0, acc + 2, 32'h0B00_EA4E, 5'd12);

      // Reset pulse with ops in flight.
      cap.delete();
      issue(MUL_, 64'd6, 64'd7, 5'd13);
      issue(MULHU_, 64'hFFFF_FFFF, 64'd2, 5'd14);
      drive(1'b0, MUL_, 64'd0, 64'd0, 5'd0, 1'b1, 1'b0, 1'b1);
      idles(1);
      chk("t5_valid", {63'd0, v0}, 64'd0);
      chk("t5_result", {32'd0, r0}, 64'd0);
      chk("t5_tag", {59'd0, t0}, 64'd0);
      chk("t5_busy", {61'd0, bz0, bz1, bz2}, 64'd0);
      idles(8);
      chk("t5_none", 64'(cap.size()), 64'd0);

      // Random stream; the per-cycle compare process carries the checking.
      for (int n = 0; n < 3000; n++) begin
         drive(($urandom % 10) < 7, mul_ops_e'(3'($urandom_range(0, 4))), rnd_operand(),
               rnd_operand(), 5'($urandom), ($urandom % 10) != 0, ($urandom % 10) == 0,
               ($urandom % 250) == 0);
      end
      idles(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
